stage_fetch: RTL and testbench
==============================

STAGE_FETCH -- requirements
Module: stage_fetch

Parameters
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter BTB_ENTRIES, default 16, giving the number of direct-mapped BTB entries; legal values are powers of two from 4 to 64; IDX = log2(BTB_ENTRIES).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-low.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the PC (decode stall).
REQ-006 The block SHALL have port redirect, input, 1 bit: mispredict or control transfer resolved downstream.
REQ-007 The block SHALL have port redirectPc, input, 32 bits: the correct next PC when redirect=1.
REQ-008 The block SHALL have port imemData, input, 32 bits: combinational instruction-memory read data for imemAddr.
REQ-009 The block SHALL have port btbUpdate, input, 1 bit: a resolved branch/jump update is valid this cycle.
REQ-010 The block SHALL have port btbUpdatePc, input, 32 bits: PC of the resolved instruction.
REQ-011 The block SHALL have port btbUpdateTarget, input, 32 bits: resolved target.
REQ-012 The block SHALL have port btbUpdateTaken, input, 1 bit: resolved direction.
REQ-013 The block SHALL have port imemAddr, output, 32 bits: equal to the current PC register.
REQ-014 The block SHALL have port instrF, output, 32 bits: equal to imemData.
REQ-015 The block SHALL have port pcF, output, 32 bits: the current PC.
REQ-016 The block SHALL have port pcPlus4F, output, 32 bits: pcF+4, modulo 2^32.
REQ-017 The block SHALL have port bPredictedTakenF, output, 1 bit: the BTB predicts taken for pcF.

Function
REQ-018 Each BTB entry SHALL hold: valid, tag = pc[31:IDX+2], target[31:0], and a 2-bit saturating counter; the entry index SHALL be pc[IDX+1:2].
REQ-019 Lookup SHALL be combinational on pcF; a hit requires valid and a tag match; bPredictedTakenF = hit & counter>=2.
REQ-020 The next PC SHALL be chosen by fixed priority: reset -> RESET_PC; redirect -> redirectPc; stall -> hold; bPredictedTakenF -> BTB target; otherwise pcPlus4F.
REQ-021 Redirect SHALL take effect even when stall=1 in the same cycle; the fetched PC on the next cycle equals redirectPc.
REQ-022 BTB updates SHALL be written at posedge and SHALL be independent of stall and redirect.
REQ-023 On an update that hits: the counter increments when taken (saturating at 3) or decrements when not taken (saturating at 0); the target is overwritten only when taken.
REQ-024 On an update that misses and is taken: the entry SHALL be allocated or overwritten with valid=1, the new tag and target, and counter=2.
REQ-025 On an update that misses and is not taken: the BTB SHALL be unchanged.
REQ-026 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents.
REQ-027 PC arithmetic SHALL wrap: PC 32'hFFFF_FFFC gives pcPlus4F = 32'h0000_0000; low PC bits SHALL pass through unmodified (no alignment check).
REQ-028 The latency from redirect or prediction to the new pcF SHALL be exactly 1 cycle.

Reset
REQ-029 While rst=0 at posedge: PC <= RESET_PC and all BTB valid bits are cleared; counters and targets are don't-care.
REQ-030 Reset SHALL take priority over redirect, stall and btbUpdate; an update presented during reset is discarded.
REQ-031 After reset: pcF=RESET_PC, pcPlus4F=RESET_PC+4, bPredictedTakenF=0, imemAddr=RESET_PC, instrF=imemData.

Verification
REQ-032 Reset then 4 free cycles with no stall -> pcF sequence is 0, 4, 8, 12; bPredictedTakenF=0 throughout.
REQ-033 Update pc=0x10, target=0x40, taken; then run from 0 -> pcF sequence is 0x0C, 0x10 (bPredictedTakenF=1), 0x40.
REQ-034 Two not-taken updates on 0x10 after the REQ-033 setup -> counter goes 2->1->0; fetching 0x10 then gives bPredictedTakenF=0 and next pcF=0x14.
REQ-035 stall=1 and redirect=1 with redirectPc=0x200 in the same cycle -> next pcF=0x200; a following stall-only cycle holds pcF at 0x200.
REQ-036 Aliasing with BTB_ENTRIES=16: an entry at 0x10 and a taken update at 0x50 (same index, different tag) -> the entry is replaced; fetching 0x10 then gives bPredictedTakenF=0.
REQ-037 rst=0 asserted mid-run together with btbUpdate -> next pcF=RESET_PC, and a previously trained PC later gives bPredictedTakenF=0.

Source files
------------

// File: rtl/stage_fetch_if.sv
// Bundle of the fetch-stage control, BTB-update and fetch-output signals.
// There is no valid/ready handshake on this bundle: btbUpdate is a
// single-cycle valid qualifier for the btbUpdate* fields and is always
// accepted (no backpressure). stall and redirect are level controls sampled
// at every posedge. Every fetch output is combinational from the PC register
// and imemData.
interface stage_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] imemData;
    logic        btbUpdate;
    logic [31:0] btbUpdatePc;
    logic [31:0] btbUpdateTarget;
    logic        btbUpdateTaken;
    logic [31:0] imemAddr;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        bPredictedTakenF;

    // Downstream pipeline / memory side
    modport master (
        output stall, redirect, redirectPc, imemData,
               btbUpdate, btbUpdatePc, btbUpdateTarget, btbUpdateTaken,
        input  imemAddr, instrF, pcF, pcPlus4F, bPredictedTakenF
    );

    // Fetch stage side
    modport slave (
        input  stall, redirect, redirectPc, imemData,
               btbUpdate, btbUpdatePc, btbUpdateTarget, btbUpdateTaken,
        output imemAddr, instrF, pcF, pcPlus4F, bPredictedTakenF
    );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC register with next-PC selection and a
// direct-mapped branch target buffer with 2-bit saturating counters.
module stage_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    stage_fetch_if.slave bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    // PC register
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;

    // BTB storage; only the valid bits are reset, the payload is don't-care
    // while invalid.
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    // Lookup side (indexed by the current PC)
    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic             pred_taken;

    // Update side (indexed by the resolved instruction PC)
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_train;
    logic             upd_alloc;
    logic [1:0]       ctr_upd;

    assign pc_plus4 = pc_q + 32'd4;

    assign look_idx   = pc_q[IDX+1:2];
    assign look_tag   = pc_q[31:IDX+2];
    assign look_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign pred_taken = look_hit && ctr_q[look_idx][1];

    assign upd_idx   = bus.btbUpdatePc[IDX+1:2];
    assign upd_tag   = bus.btbUpdatePc[31:IDX+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_train = bus.btbUpdate && upd_hit;
    assign upd_alloc = bus.btbUpdate && !upd_hit && bus.btbUpdateTaken;

    // Next counter value: saturating train on a hit, weakly-taken on allocate
    always_comb begin
        ctr_upd = ctr_q[upd_idx];
        if (upd_hit) begin
            if (bus.btbUpdateTaken) begin
                if (ctr_q[upd_idx] != 2'd3) ctr_upd = ctr_q[upd_idx] + 2'd1;
            end else begin
                if (ctr_q[upd_idx] != 2'd0) ctr_upd = ctr_q[upd_idx] - 2'd1;
            end
        end else begin
            ctr_upd = 2'd2;
        end
    end

    // Next-PC priority below reset: redirect, stall, predicted target, PC+4
    always_comb begin
        pc_d = pc_plus4;
        if (bus.redirect) begin
            pc_d = bus.redirectPc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = target_q[look_idx];
        end
    end

    // PC and valid bits; reset wins over everything, including BTB updates
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (upd_alloc) valid_q[upd_idx] <= 1'b1;
        end
    end

    // BTB payload writes; independent of stall/redirect, dropped during reset
    always_ff @(posedge clk) begin
        if (rst && (upd_train || upd_alloc)) begin
            ctr_q[upd_idx] <= ctr_upd;
            if (bus.btbUpdateTaken) target_q[upd_idx] <= bus.btbUpdateTarget;
            if (upd_alloc) tag_q[upd_idx] <= upd_tag;
        end
    end

    assign bus.imemAddr         = pc_q;
    assign bus.pcF              = pc_q;
    assign bus.pcPlus4F         = pc_plus4;
    assign bus.instrF           = bus.imemData;
    assign bus.bPredictedTakenF = pred_taken;
endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios plus a randomized
// run, all compared against a behavioural fetch/BTB model.
module tb_stage_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N        = 16;
    localparam int          IDX      = $clog2(N);

    logic clk;
    logic rst;
    stage_fetch_if bus();

    stage_fetch #(.RESET_PC(RESET_PC), .BTB_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    function automatic logic model_pred();
        int i;
        i = idx_of(m_pc);
        return m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
    endfunction

    // Driver: present one cycle of inputs while the clock is low
    task automatic apply(input logic r, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic up,
                         input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utk);
        rst                 = r;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirectPc      = rpc;
        bus.btbUpdate       = up;
        bus.btbUpdatePc     = upc;
        bus.btbUpdateTarget = utgt;
        bus.btbUpdateTaken  = utk;
        bus.imemData        = $urandom;
        #1;
    endtask

    task automatic idle();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Advance one clock and step the model with the inputs just applied
    task automatic tick();
        logic [31:0] nxt;
        int          i;
        int          u;
        @(posedge clk);
        if (!rst) begin
            m_pc = RESET_PC;
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        end else begin
            i = idx_of(m_pc);
            if (bus.redirect)     nxt = bus.redirectPc;
            else if (bus.stall)   nxt = m_pc;
            else if (model_pred()) nxt = m_tgt[i];
            else                  nxt = m_pc + 32'd4;
            if (bus.btbUpdate) begin
                u = idx_of(bus.btbUpdatePc);
                if (m_valid[u] && m_tag[u] == tag_of(bus.btbUpdatePc)) begin
                    if (bus.btbUpdateTaken) begin
                        m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
                        m_tgt[u] = bus.btbUpdateTarget;
                    end else begin
                        m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
                    end
                end else if (bus.btbUpdateTaken) begin
                    m_valid[u] = 1'b1;
                    m_tag[u]   = tag_of(bus.btbUpdatePc);
                    m_tgt[u]   = bus.btbUpdateTarget;
                    m_ctr[u]   = 2;
                end
            end
            m_pc = nxt;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 32'h0, 32'h0000_0900, 1'b1);
        tick();
        tick();
        idle();
        n_vec++; if (bus.pcF !== RESET_PC) begin n_err++; $display("FAIL reset_pcF: got %h expected %h", bus.pcF, RESET_PC); end
        n_vec++; if (bus.pcPlus4F !== RESET_PC + 32'd4) begin n_err++; $display("FAIL reset_pcPlus4F: got %h expected %h", bus.pcPlus4F, RESET_PC + 32'd4); end
        n_vec++; if (bus.imemAddr !== RESET_PC) begin n_err++; $display("FAIL reset_imemAddr: got %h expected %h", bus.imemAddr, RESET_PC); end
        n_vec++; if (bus.instrF !== bus.imemData) begin n_err++; $display("FAIL reset_instrF: got %h expected %h", bus.instrF, bus.imemData); end
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b expected 0", bus.bPredictedTakenF); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            idle();
            n_vec++; if (bus.pcF !== 32'(i * 4)) begin n_err++; $display("FAIL seq_pcF[%0d]: got %h expected %h", i, bus.pcF, 32'(i * 4)); end
            n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL seq_pred[%0d]: got %b expected 0", i, bus.bPredictedTakenF); end
            tick();
        end
    endtask

    task automatic test_btb_train();
        logic [31:0] exp_pc [6];
        logic        exp_pr [6];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40};
        exp_pr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            idle();
            n_vec++; if (bus.pcF !== exp_pc[i]) begin n_err++; $display("FAIL train_pcF[%0d]: got %h expected %h", i, bus.pcF, exp_pc[i]); end
            n_vec++; if (bus.bPredictedTakenF !== exp_pr[i]) begin n_err++; $display("FAIL train_pred[%0d]: got %b expected %b", i, bus.bPredictedTakenF, exp_pr[i]); end
            tick();
        end
    endtask

    task automatic test_not_taken();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0);
            tick();
        end
        apply(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h10) begin n_err++; $display("FAIL nt_pcF: got %h expected 00000010", bus.pcF); end
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL nt_pred: got %b expected 0", bus.bPredictedTakenF); end
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h14) begin n_err++; $display("FAIL nt_next: got %h expected 00000014", bus.pcF); end
        tick();
    endtask

    task automatic test_stall_redirect();
        apply(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_vec++; if (bus.pcF !== 32'h200) begin n_err++; $display("FAIL stallredir_pcF: got %h expected 00000200", bus.pcF); end
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h200) begin n_err++; $display("FAIL stall_hold: got %h expected 00000200", bus.pcF); end
        tick();
    endtask

    task automatic test_alias();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1);
            tick();
        end
        apply(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b1) begin n_err++; $display("FAIL alias_retrain: got %b expected 1", bus.bPredictedTakenF); end
        tick();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h50, 32'h80, 1'b1);
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL alias_evicted: got %b expected 0", bus.bPredictedTakenF); end
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b1) begin n_err++; $display("FAIL alias_new_pred: got %b expected 1", bus.bPredictedTakenF); end
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h80) begin n_err++; $display("FAIL alias_target: got %h expected 00000080", bus.pcF); end
        tick();
    endtask

    task automatic test_same_index();
        apply(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h300, 1'b1);
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL same_idx_pred: got %b expected 0", bus.bPredictedTakenF); end
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        n_vec++; if (bus.pcF !== 32'h24) begin n_err++; $display("FAIL same_idx_next: got %h expected 00000024", bus.pcF); end
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b1) begin n_err++; $display("FAIL same_idx_later: got %b expected 1", bus.bPredictedTakenF); end
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h300) begin n_err++; $display("FAIL same_idx_target: got %h expected 00000300", bus.pcF); end
        tick();
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.pcPlus4F !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h expected 00000000", bus.pcPlus4F); end
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 32'h0, 1'b0);
        n_vec++; if (bus.pcF !== 32'h0) begin n_err++; $display("FAIL wrap_pcF: got %h expected 00000000", bus.pcF); end
        tick();
        idle();
        n_vec++; if (bus.pcF !== 32'h103) begin n_err++; $display("FAIL unaligned_pcF: got %h expected 00000103", bus.pcF); end
        n_vec++; if (bus.pcPlus4F !== 32'h107) begin n_err++; $display("FAIL unaligned_plus4: got %h expected 00000107", bus.pcPlus4F); end
        tick();
    endtask

    task automatic test_reset_midrun();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 32'h500, 1'b1);
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b1) begin n_err++; $display("FAIL midrst_trained: got %b expected 1", bus.bPredictedTakenF); end
        apply(1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h90, 32'h400, 1'b1);
        tick();
        idle();
        n_vec++; if (bus.pcF !== RESET_PC) begin n_err++; $display("FAIL midrst_pcF: got %h expected %h", bus.pcF, RESET_PC); end
        tick();
        apply(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL midrst_cleared: got %b expected 0", bus.bPredictedTakenF); end
        apply(1'b1, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++; if (bus.bPredictedTakenF !== 1'b0) begin n_err++; $display("FAIL midrst_dropped_upd: got %b expected 0", bus.bPredictedTakenF); end
        tick();
    endtask

    task automatic test_random();
        logic        r, st, rd, up, utk;
        logic [31:0] rpc, upc, utgt;
        for (int c = 0; c < 400; c++) begin
            r    = ($urandom_range(0, 49) != 0);
            st   = ($urandom_range(0, 3) == 0);
            rd   = ($urandom_range(0, 7) == 0);
            rpc  = 32'($urandom_range(0, 255)) << 2;
            up   = ($urandom_range(0, 2) == 0);
            upc  = ($urandom_range(0, 1) == 1) ? m_pc : (32'($urandom_range(0, 127)) << 2);
            utgt = 32'($urandom_range(0, 255)) << 2;
            utk  = 1'($urandom_range(0, 1));
            apply(r, st, rd, rpc, up, upc, utgt, utk);
            n_vec++; if (bus.pcF !== m_pc) begin n_err++; $display("FAIL rand_pcF[%0d]: got %h expected %h", c, bus.pcF, m_pc); end
            n_vec++; if (bus.imemAddr !== m_pc) begin n_err++; $display("FAIL rand_imemAddr[%0d]: got %h expected %h", c, bus.imemAddr, m_pc); end
            n_vec++; if (bus.pcPlus4F !== m_pc + 32'd4) begin n_err++; $display("FAIL rand_plus4[%0d]: got %h expected %h", c, bus.pcPlus4F, m_pc + 32'd4); end
            n_vec++; if (bus.instrF !== bus.imemData) begin n_err++; $display("FAIL rand_instrF[%0d]: got %h expected %h", c, bus.instrF, bus.imemData); end
            n_vec++; if (bus.bPredictedTakenF !== model_pred()) begin n_err++; $display("FAIL rand_pred[%0d]: got %b expected %b", c, bus.bPredictedTakenF, model_pred()); end
            tick();
        end
    endtask

    initial begin
        m_pc = RESET_PC;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = '0;
            m_tgt[k]   = '0;
            m_ctr[k]   = 0;
        end
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_btb_train();
        test_not_taken();
        test_stall_redirect();
        test_alias();
        test_same_index();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
